// File: rtl/hoplite_rt_inj_switch_if.sv
`default_nettype none
// ============================================================================
// Module   : hoplite_rt_inj_switch_if
// Purpose  : Network and PE-injection signal bundle of the Hoplite switch.
// Revision : 1.0 - initial release
// ============================================================================
interface hoplite_rt_inj_switch_if #(
    parameter int P_W = 12
);
    logic [P_W-1:0] x_in_data;
    logic           x_in_valid;
    logic [P_W-1:0] y_in_data;
    logic           y_in_valid;
    logic [P_W-1:0] pe_in_data;
    logic           pe_in_valid;
    logic           pe_in_ready;
    logic [P_W-1:0] x_out_data;
    logic           x_out_valid;
    logic [P_W-1:0] y_out_data;
    logic           y_out_valid;
    logic           valid;

    modport master (
        output x_in_data, x_in_valid, y_in_data, y_in_valid, pe_in_data, pe_in_valid,
        input  pe_in_ready, x_out_data, x_out_valid, y_out_data, y_out_valid, valid
    );

    modport slave (
        input  x_in_data, x_in_valid, y_in_data, y_in_valid, pe_in_data, pe_in_valid,
        output pe_in_ready, x_out_data, x_out_valid, y_out_data, y_out_valid, valid
    );
endinterface
`default_nettype wire

// File: rtl/hoplite_rt_inj_switch.sv
`default_nettype none
// ============================================================================
// Module   : hoplite_rt_inj_switch
// Purpose  : Hoplite torus deflection switch with FIFO + token-bucket PE
//            injection. Macro HOPLITE_STATS_EN adds deflection/stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module hoplite_rt_inj_switch #(
    parameter int D_W        = 8,
    parameter int X_DIM      = 4,
    parameter int Y_DIM      = 4,
    parameter int X_POS      = 0,
    parameter int Y_POS      = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int TB_PERIOD  = 4,
    parameter int TB_BURST   = 2
) (
    input  wire logic               clk,
    input  wire logic               rst,
    hoplite_rt_inj_switch_if.slave  bus
`ifdef HOPLITE_STATS_EN
    ,
    output logic [15:0]             defl_count,
    output logic [15:0]             stall_count
`endif
);
    localparam int X_W  = (X_DIM > 1) ? $clog2(X_DIM) : 1;
    localparam int Y_W  = (Y_DIM > 1) ? $clog2(Y_DIM) : 1;
    localparam int P_W  = D_W + X_W + Y_W;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int PC_W = (TB_PERIOD > 1) ? $clog2(TB_PERIOD) : 1;
    localparam int TK_W = $clog2(TB_BURST + 1);

    localparam logic [X_W-1:0]  c_x_pos       = X_W'(X_POS);
    localparam logic [Y_W-1:0]  c_y_pos       = Y_W'(Y_POS);
    localparam logic [AW:0]     c_depth       = (AW + 1)'(FIFO_DEPTH);
    localparam logic [PC_W-1:0] c_period_last = PC_W'(TB_PERIOD - 1);
    localparam logic [TK_W-1:0] c_burst       = TK_W'(TB_BURST);

    function automatic logic hits_x(input logic [P_W-1:0] p);
        return p[D_W +: X_W] == c_x_pos;
    endfunction

    function automatic logic hits_y(input logic [P_W-1:0] p);
        return p[D_W + X_W +: Y_W] == c_y_pos;
    endfunction

    logic [P_W-1:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [AW:0]     r_count;
    logic            r_ready;
    logic [TK_W-1:0] r_tokens;
    logic [PC_W-1:0] r_period;
    logic [P_W-1:0]  r_x_out_data, r_y_out_data;
    logic            r_x_out_valid, r_y_out_valid, r_valid;

    logic [P_W-1:0]  w_head, w_e_data, w_s_data;
    logic            w_x_wants_s, w_x_to_s, w_x_to_e, w_head_xm, w_inj;
    logic            w_e_valid, w_s_valid, w_s_exit, w_push, w_wrap;
    logic [AW:0]     w_count_next;
    logic [TK_W:0]   w_tok_sum;
    logic [TK_W-1:0] w_tok_next;

    assign w_head = r_mem[r_rd_ptr];

    always_comb begin
        w_x_wants_s = bus.x_in_valid && hits_x(bus.x_in_data);
        // y_in owns the S port; an x_in packet that wanted it is deflected E
        w_x_to_s    = w_x_wants_s && !bus.y_in_valid;
        w_x_to_e    = bus.x_in_valid && !w_x_to_s;
        w_head_xm   = hits_x(w_head);
        w_inj       = (r_count != '0) && (r_tokens != '0) &&
                      (w_head_xm ? !(bus.y_in_valid || w_x_to_s) : !w_x_to_e);

        w_e_valid = 1'b0;
        w_e_data  = '0;
        if (w_x_to_e) begin
            w_e_valid = 1'b1;
            w_e_data  = bus.x_in_data;
        end else if (w_inj && !w_head_xm) begin
            w_e_valid = 1'b1;
            w_e_data  = w_head;
        end

        w_s_valid = 1'b0;
        w_s_data  = '0;
        if (bus.y_in_valid) begin
            w_s_valid = 1'b1;
            w_s_data  = bus.y_in_data;
        end else if (w_x_to_s) begin
            w_s_valid = 1'b1;
            w_s_data  = bus.x_in_data;
        end else if (w_inj && w_head_xm) begin
            w_s_valid = 1'b1;
            w_s_data  = w_head;
        end
        w_s_exit = hits_x(w_s_data) && hits_y(w_s_data);

        w_push       = bus.pe_in_valid && r_ready;
        w_count_next = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_inj};
        w_wrap       = (r_period == c_period_last);
        // consume and refill in one cycle cancel; the sum saturates at the burst size
        w_tok_sum    = {1'b0, r_tokens} + {{TK_W{1'b0}}, w_wrap} - {{TK_W{1'b0}}, w_inj};
        w_tok_next   = (w_tok_sum > {1'b0, c_burst}) ? c_burst : w_tok_sum[TK_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_ready       <= 1'b1;
            r_tokens      <= c_burst;
            r_period      <= '0;
            r_x_out_data  <= '0;
            r_x_out_valid <= 1'b0;
            r_y_out_data  <= '0;
            r_y_out_valid <= 1'b0;
            r_valid       <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_inj)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count       <= w_count_next;
            r_ready       <= (w_count_next != c_depth);
            r_tokens      <= w_tok_next;
            r_period      <= w_wrap ? '0 : r_period + PC_W'(1);
            r_x_out_data  <= w_e_data;
            r_x_out_valid <= w_e_valid;
            r_y_out_data  <= w_s_data;
            r_y_out_valid <= w_s_valid && !w_s_exit;
            r_valid       <= w_s_valid && w_s_exit;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.pe_in_data;
    end

    assign bus.pe_in_ready = r_ready;
    assign bus.x_out_data  = r_x_out_data;
    assign bus.x_out_valid = r_x_out_valid;
    assign bus.y_out_data  = r_y_out_data;
    assign bus.y_out_valid = r_y_out_valid;
    assign bus.valid       = r_valid;

`ifdef HOPLITE_STATS_EN
    logic [15:0] r_defl, r_stall;
    logic        w_defl, w_stall;

    assign w_defl  = w_x_wants_s && bus.y_in_valid;
    assign w_stall = (r_count != '0) && !w_inj;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_defl  <= '0;
            r_stall <= '0;
        end else begin
            if (w_defl && (r_defl != 16'hFFFF))   r_defl  <= r_defl + 16'd1;
            if (w_stall && (r_stall != 16'hFFFF)) r_stall <= r_stall + 16'd1;
        end
    end

    assign defl_count  = r_defl;
    assign stall_count = r_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hoplite_rt_inj_switch.sv
`default_nettype none
// ============================================================================
// Module   : tb_hoplite_rt_inj_switch
// Purpose  : Self-checking bench for hoplite_rt_inj_switch at node (1,2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hoplite_rt_inj_switch;
    localparam int D_W = 8, X_DIM = 4, Y_DIM = 4, X_POS = 1, Y_POS = 2;
    localparam int FIFO_DEPTH = 4, TB_PERIOD = 4, TB_BURST = 2;
    localparam int P_W = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hoplite_rt_inj_switch_if #(.P_W(P_W)) bus ();
`ifdef HOPLITE_STATS_EN
    logic [15:0] defl_count, stall_count;
`endif

    hoplite_rt_inj_switch #(
        .D_W(D_W), .X_DIM(X_DIM), .Y_DIM(Y_DIM), .X_POS(X_POS), .Y_POS(Y_POS),
        .FIFO_DEPTH(FIFO_DEPTH), .TB_PERIOD(TB_PERIOD), .TB_BURST(TB_BURST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef HOPLITE_STATS_EN
        , .defl_count(defl_count), .stall_count(stall_count)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // reference model state
    logic [P_W-1:0] m_q[$];
    int             m_tokens, m_period, m_defl, m_stall;
    bit             m_ready;
    bit             e_xv, e_yv, e_v;
    logic [P_W-1:0] e_xd, e_yd;

    function automatic logic [P_W-1:0] pkt(input int y, input int x, input int d);
        return {2'(y), 2'(x), 8'(d)};
    endfunction
    function automatic bit at_x(input logic [P_W-1:0] p);
        return int'(p[9:8]) == X_POS;
    endfunction
    function automatic bit at_y(input logic [P_W-1:0] p);
        return int'(p[11:10]) == Y_POS;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic set_in(input bit xv, input logic [P_W-1:0] xd, input bit yv,
                          input logic [P_W-1:0] yd, input bit pv, input logic [P_W-1:0] pd);
        bus.x_in_valid  = xv; bus.x_in_data  = xd;
        bus.y_in_valid  = yv; bus.y_in_data  = yd;
        bus.pe_in_valid = pv; bus.pe_in_data = pd;
    endtask

    // Predicts the outputs after the coming clock edge from the current inputs.
    task automatic model_step();
        bit s_have = 0, e_have = 0, inj = 0, had = 0;
        logic [P_W-1:0] s_pkt = '0, e_pkt = '0, head;
        if (rst) begin
            m_q.delete();
            m_tokens = TB_BURST; m_period = 0; m_ready = 1;
            m_defl = 0; m_stall = 0;
            e_xv = 0; e_yv = 0; e_v = 0; e_xd = '0; e_yd = '0;
            return;
        end
        if (bus.y_in_valid) begin s_have = 1; s_pkt = bus.y_in_data; end
        if (bus.x_in_valid) begin
            if (at_x(bus.x_in_data) && !s_have) begin
                s_have = 1; s_pkt = bus.x_in_data;
            end else begin
                e_have = 1; e_pkt = bus.x_in_data;
                if (at_x(bus.x_in_data) && m_defl < 65535) m_defl++;
            end
        end
        had = (m_q.size() > 0);
        if (had && m_tokens > 0) begin
            head = m_q[0];
            if (at_x(head) ? !s_have : !e_have) begin
                inj = 1;
                if (at_x(head)) begin s_have = 1; s_pkt = head; end
                else begin e_have = 1; e_pkt = head; end
                void'(m_q.pop_front());
                m_tokens--;
            end
        end
        if (had && !inj && m_stall < 65535) m_stall++;
        m_period++;
        if (m_period == TB_PERIOD) begin
            m_period = 0;
            if (m_tokens < TB_BURST) m_tokens++;
        end
        if (bus.pe_in_valid && m_ready) m_q.push_back(bus.pe_in_data);
        m_ready = (m_q.size() < FIFO_DEPTH);
        e_xv = e_have; e_xd = e_have ? e_pkt : '0;
        e_yv = s_have && !(at_x(s_pkt) && at_y(s_pkt));
        e_v  = s_have &&  (at_x(s_pkt) && at_y(s_pkt));
        e_yd = s_have ? s_pkt : '0;
    endtask

    task automatic step();
        model_step();
        @(posedge clk); #1; cyc++;
        check("x_out_valid", bus.x_out_valid, e_xv);
        if (e_xv) check("x_out_data", bus.x_out_data, e_xd);
        check("y_out_valid", bus.y_out_valid, e_yv);
        check("valid", bus.valid, e_v);
        if (e_yv || e_v) check("y_out_data", bus.y_out_data, e_yd);
        check("pe_in_ready", bus.pe_in_ready, m_ready);
`ifdef HOPLITE_STATS_EN
        check("defl_count", defl_count, m_defl);
        check("stall_count", stall_count, m_stall);
`endif
    endtask

    task automatic reset_and_check();
        rst = 1'b1;
        set_in(0, '0, 0, '0, 0, '0);
        step(); step();
        check("rst_x_valid", bus.x_out_valid, 0);
        check("rst_y_valid", bus.y_out_valid, 0);
        check("rst_valid", bus.valid, 0);
        check("rst_x_data", bus.x_out_data, 0);
        check("rst_y_data", bus.y_out_data, 0);
        check("rst_ready", bus.pe_in_ready, 1);
        rst = 1'b0;
    endtask

    typedef struct {
        bit xv; logic [P_W-1:0] xd;
        bit yv; logic [P_W-1:0] yd;
        bit exv; logic [P_W-1:0] exd;
        bit eyv; bit ev; logic [P_W-1:0] eyd;
        bit defl;
    } vec_t;
    vec_t vecs[9];

    initial begin
        int tdefl = 0;
        int seen_d[$];
        int seen_t[$];
        int k;

        vecs[0] = '{1, pkt(3,1,'hA5), 0, '0, 0, '0, 1, 0, pkt(3,1,'hA5), 0};
        vecs[1] = '{1, pkt(2,1,'h5A), 0, '0, 0, '0, 0, 1, pkt(2,1,'h5A), 0};
        vecs[2] = '{1, pkt(2,3,'h11), 0, '0, 1, pkt(2,3,'h11), 0, 0, '0, 0};
        vecs[3] = '{0, '0, 1, pkt(2,1,'h22), 0, '0, 0, 1, pkt(2,1,'h22), 0};
        vecs[4] = '{0, '0, 1, pkt(0,3,'h33), 0, '0, 1, 0, pkt(0,3,'h33), 0};
        vecs[5] = '{1, pkt(0,1,'h44), 1, pkt(3,1,'h55), 1, pkt(0,1,'h44), 1, 0, pkt(3,1,'h55), 1};
        vecs[6] = '{1, pkt(2,1,'h66), 1, pkt(2,1,'h77), 1, pkt(2,1,'h66), 0, 1, pkt(2,1,'h77), 1};
        vecs[7] = '{1, pkt(1,0,'h88), 1, pkt(1,2,'h99), 1, pkt(1,0,'h88), 1, 0, pkt(1,2,'h99), 0};
        vecs[8] = '{0, '0, 0, '0, 0, '0, 0, 0, '0, 0};

        reset_and_check();

        // routing table with an empty injection FIFO
        for (int i = 0; i < 9; i++) begin
            set_in(vecs[i].xv, vecs[i].xd, vecs[i].yv, vecs[i].yd, 0, '0);
            step();
            tdefl += vecs[i].defl;
            check("vec_x_valid", bus.x_out_valid, vecs[i].exv);
            if (vecs[i].exv) check("vec_x_data", bus.x_out_data, vecs[i].exd);
            check("vec_y_valid", bus.y_out_valid, vecs[i].eyv);
            check("vec_exit_valid", bus.valid, vecs[i].ev);
            if (vecs[i].eyv || vecs[i].ev) check("vec_y_data", bus.y_out_data, vecs[i].eyd);
`ifdef HOPLITE_STATS_EN
            check("vec_defl", defl_count, tdefl);
`endif
        end

        // reset mid-stream drops a buffered packet
        set_in(1, pkt(0,3,'hEE), 0, '0, 1, pkt(0,2,'hBB));
        step();
        reset_and_check();
        set_in(0, '0, 0, '0, 0, '0);
        for (int i = 0; i < 8; i++) begin
            step();
            check("no_ghost_e", bus.x_out_valid, 0);
        end

        // blocked head: fill FIFO, 5th push refused, then burst + rate-limited drain
        for (int i = 0; i < 10; i++) begin
            set_in(1, pkt(0,3,'hEE), 0, '0, i < 5, pkt(0,2,'hC0 + i));
            step();
            if (i == 3) check("ready_full", bus.pe_in_ready, 0);
            if (i >= 5) check("blocked_ready", bus.pe_in_ready, 0);
        end
        set_in(0, '0, 0, '0, 0, '0);
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.x_out_valid && bus.x_out_data[9:8] == 2'd2) begin
                seen_d.push_back(int'(bus.x_out_data[7:0]));
                seen_t.push_back(i);
            end
        end
        check("burst_count", seen_d.size(), 4);
        for (int i = 0; i < seen_d.size(); i++) check("burst_order", seen_d[i], 'hC0 + i);
        if (seen_t.size() == 4) begin
            check("first_inj_time", seen_t[0], 0);
            check("burst_gap", seen_t[1] - seen_t[0], 1);
            check("rate_gap", seen_t[3] - seen_t[2], TB_PERIOD);
        end

        // simultaneous push/pop at 3 entries and pointer wrap over 8 packets
        seen_d.delete();
        for (int i = 0; i < 3; i++) begin
            set_in(1, pkt(0,3,'hEE), 0, '0, 1, pkt(0,2,i));
            step();
        end
        set_in(0, '0, 0, '0, 1, pkt(0,2,3));
        step();
        check("pushpop_ready", bus.pe_in_ready, 1);
        check("pushpop_inj", bus.x_out_data, pkt(0,2,0));
        if (bus.x_out_valid && bus.x_out_data[9:8] == 2'd2) seen_d.push_back(int'(bus.x_out_data[7:0]));
        k = 4;
        for (int i = 0; i < 60; i++) begin
            set_in(0, '0, 0, '0, k < 8, pkt(0,2,k));
            if (k < 8 && m_ready) k++;
            step();
            if (bus.x_out_valid && bus.x_out_data[9:8] == 2'd2) seen_d.push_back(int'(bus.x_out_data[7:0]));
        end
        check("wrap_count", seen_d.size(), 8);
        for (int i = 0; i < seen_d.size(); i++) check("wrap_order", seen_d[i], i);

        // randomized traffic against the model, with occasional resets
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            set_in($urandom_range(0, 1), P_W'($urandom), $urandom_range(0, 2) == 0,
                   P_W'($urandom), $urandom_range(0, 1), P_W'($urandom));
            step();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
